uart_host_loader: RTL and testbench
===================================

# uart_host_loader

Host-side peer of the core's UART IO state machine: waits for the core's 0x99 load request, transmits a 32-bit program size followed by the program words, waits for the 0xaa input-ready marker, then streams stdin bytes to the core and captures bytes the core sends back. Used as the far end of the link in simulation benches and on a second FPGA acting as a standalone loader. Contains its own 8N1 serializer and deserializer.

## Interface
- CLK_PER_HALF_BIT, 434, clock cycles per half UART bit; bit period = 2*CLK_PER_HALF_BIT
- GAP_BITS, 2, idle bit periods inserted between transmitted bytes (only with UART_HOST_GAP_EN)

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a load session from IDLE
- rxd  in  1  serial from core txd (asynchronous; 2-flop synchronized internally)
- txd  out  1  serial to core rxd; reset 1
- prog_size  in  32  program size in bytes, sampled on start
- prog_addr  out  30  word index into program memory; reset 0
- prog_data  in  32  program word at prog_addr, valid the cycle after prog_addr changes
- in_data  in  8  stdin byte
- in_valid  in  1  stdin byte valid
- in_ready  out  1  accepts in_data; reset 0
- out_data  out  8  byte captured from core; reset 0
- out_valid  out  1  one-cycle pulse per captured byte; reset 0
- state  out  3  current FSM state; reset 0 (IDLE)
- size_err  out  1  sticky: prog_size[1:0] nonzero at start; reset 0
- frame_err  out  1  sticky: received stop bit was 0; reset 0

## Operation
- States (encoding): IDLE=0, WAIT_REQ=1, SEND_SIZE=2, SEND_PROG=3, WAIT_RDY=4, STREAM=5.
- IDLE: start → latch size = {prog_size[31:2],2'b00}, set size_err if prog_size[1:0]!=0; → WAIT_REQ.
- WAIT_REQ: first received 0x99 → SEND_SIZE; all other bytes discarded.
- SEND_SIZE: transmit latched size, 4 bytes, least-significant byte first. After 4th byte: size==0 → WAIT_RDY, else prog_addr=0 → SEND_PROG.
- SEND_PROG: per word, transmit prog_data LSB byte first; after 4th byte increment prog_addr. After word (size>>2)-1 → WAIT_RDY.
- Received bytes in SEND_SIZE/SEND_PROG (repeated 0x99 from the core) are discarded.
- WAIT_RDY: received 0xaa → STREAM; other bytes discarded.
- STREAM: in_ready=1 while serializer idle (and gap elapsed); in_valid&&in_ready accepts byte, in_ready drops next cycle. Every received byte → out_data/out_valid. Remains in STREAM until rst.
- start outside IDLE ignored.
- Receiver: falling edge on synchronized rxd, recheck low after CLK_PER_HALF_BIT (else abort, glitch), sample 8 data bits LSB first at 2*CLK_PER_HALF_BIT intervals, then stop bit. Stop=0 → byte dropped, frame_err set.
- rst mid-operation: all state to reset values immediately, txd forced 1, partially sent byte abandoned.

## Timing
- Bit period B = 2*CLK_PER_HALF_BIT cycles; frame = 10*B (start, 8 data, stop).
- Transmit byte start: txd goes low the cycle after the byte is loaded; back-to-back bytes without UART_HOST_GAP_EN (next start bit immediately after stop bit).
- Byte from rxd → out_valid: one cycle after stop-bit sample point (mid stop bit) plus 2-cycle synchronizer.
- Received 0x99 in WAIT_REQ → first size start bit within 3 cycles of stop-bit sample.
- prog_addr change → prog_data registered next cycle before first byte of word loaded.
- Counters: bit-timer width ceil(log2(2*CLK_PER_HALF_BIT)); byte counter 2 bits wraps per word; word counter 30 bits.

## Configuration
- UART_HOST_GAP_EN defined: after each stop bit txd held 1 for GAP_BITS*B more cycles before next start bit; in_ready held low during gap.
- Undefined: no gap; GAP_BITS unused.

## Test plan
- CLK_PER_HALF_BIT=4, prog_size=8, words 0x11223344,0xAABBCCDD; start, core sends 0x99 → txd bytes 08 00 00 00 44 33 22 11 DD CC BB AA, each 80 cycles, state ends 4.
- In SEND_PROG inject five more 0x99 frames → byte sequence unchanged, out_valid never pulses.
- prog_size=0 → bytes 00 00 00 00 then state=4; prog_size=6 → size_err=1, sent size 04 00 00 00, one word only.
- STREAM: core sends 0xaa, then in_data 0x41 with in_valid → txd frame 0x41; core sends 0x5A → out_valid one cycle, out_data=0x5A; simultaneous rx and tx both complete.
- rxd frame with stop=0 → frame_err=1, no out_valid; 3-cycle low glitch on rxd → no byte, no error.
- rst asserted mid-byte in SEND_SIZE → txd=1, state=0, prog_addr=0 same cycle; new start resumes from WAIT_REQ.

Source files
------------

// File: rtl/uart_host_loader.sv
// Host-side UART loader: answers the core's 0x99 request with size + program words, then bridges stdin/stdout.
// Optional inter-byte transmit gap: define UART_HOST_GAP_EN.
module uart_host_loader #(
  parameter int unsigned CLK_PER_HALF_BIT = 434,
  parameter int unsigned GAP_BITS         = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rxd,
  output logic        txd,
  input  logic [31:0] prog_size,
  output logic [29:0] prog_addr,
  input  logic [31:0] prog_data,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic [2:0]  state,
  output logic        size_err,
  output logic        frame_err
);
  localparam int unsigned BIT_CYC = 2 * CLK_PER_HALF_BIT;
  localparam int unsigned TW      = $clog2(BIT_CYC);
`ifdef UART_HOST_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif
  // Gap periods are modelled as extra always-high bit slots after the stop bit.
  localparam int unsigned TX_LAST = GAP_EN ? 9 + GAP_BITS : 9;
  localparam int unsigned CW      = $clog2(TX_LAST + 1);
  localparam logic [TW-1:0] HALF_M1 = TW'(CLK_PER_HALF_BIT - 1);
  localparam logic [TW-1:0] BIT_M1  = TW'(BIT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0, WAIT_REQ = 3'd1, SEND_SIZE = 3'd2,
    SEND_PROG = 3'd3, WAIT_RDY = 3'd4, STREAM = 3'd5
  } state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  state_t    state_q, state_d;
  rx_state_t rx_st_q, rx_st_d;
  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  logic [TW-1:0] rx_tmr_q, rx_tmr_d, tx_tmr_q, tx_tmr_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d, tx_dat_q, tx_dat_d, out_data_q, out_data_d;
  logic [CW-1:0] tx_bit_q, tx_bit_d;
  logic          tx_busy_q, tx_busy_d, txd_q, txd_d;
  logic [31:0]   size_q, size_d, word_q, word_d;
  logic [29:0]   addr_q, addr_d;
  logic [1:0]    bcnt_q, bcnt_d, fetch_q, fetch_d;
  logic          size_err_q, size_err_d, frame_err_q, frame_err_d, out_valid_q, out_valid_d;
  logic          rx_done, tx_ready, tx_load;
  logic [7:0]    tx_byte;

  always_comb begin
    state_d = state_q;   rx_st_d = rx_st_q;   rx_tmr_d = rx_tmr_q;  rx_bit_d = rx_bit_q;
    rx_sh_d = rx_sh_q;   tx_tmr_d = tx_tmr_q; tx_bit_d = tx_bit_q;  tx_busy_d = tx_busy_q;
    tx_dat_d = tx_dat_q; txd_d = txd_q;       size_d = size_q;      word_d = word_q;
    addr_d = addr_q;     bcnt_d = bcnt_q;     fetch_d = fetch_q;    size_err_d = size_err_q;
    frame_err_d = frame_err_q; out_data_d = out_data_q; out_valid_d = 1'b0;
    rx_done = 1'b0; tx_load = 1'b0; tx_byte = '0; in_ready = 1'b0;

    if (rx_tmr_q != '0) rx_tmr_d = rx_tmr_q - TW'(1);
    unique case (rx_st_q)
      RX_IDLE: if (rx_prev_q && !rx_s2_q) begin
        rx_st_d = RX_START; rx_tmr_d = HALF_M1;
      end
      RX_START: if (rx_tmr_q == '0) begin
        if (rx_s2_q) rx_st_d = RX_IDLE;
        else begin rx_st_d = RX_DATA; rx_tmr_d = BIT_M1; rx_bit_d = '0; end
      end
      RX_DATA: if (rx_tmr_q == '0) begin
        rx_sh_d = {rx_s2_q, rx_sh_q[7:1]};
        rx_tmr_d = BIT_M1;
        rx_bit_d = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
      end
      RX_STOP: if (rx_tmr_q == '0) begin
        rx_st_d = RX_IDLE;
        if (rx_s2_q) rx_done = 1'b1;
        else frame_err_d = 1'b1;
      end
      default: rx_st_d = RX_IDLE;
    endcase

    // Ready in the final cycle of a frame so consecutive bytes run back-to-back.
    tx_ready = !tx_busy_q || (tx_tmr_q == '0 && tx_bit_q == CW'(TX_LAST));
    if (tx_busy_q) begin
      if (tx_tmr_q != '0) tx_tmr_d = tx_tmr_q - TW'(1);
      else if (tx_bit_q == CW'(TX_LAST)) tx_busy_d = 1'b0;
      else begin
        tx_bit_d = tx_bit_q + CW'(1);
        tx_tmr_d = BIT_M1;
        txd_d = (tx_bit_q < CW'(8)) ? tx_dat_q[tx_bit_q[2:0]] : 1'b1;
      end
    end

    unique case (state_q)
      IDLE: if (start) begin
        size_d = {prog_size[31:2], 2'b00};
        size_err_d = size_err_q | (prog_size[1:0] != 2'b00);
        state_d = WAIT_REQ;
      end
      WAIT_REQ: if (rx_done && rx_sh_q == 8'h99) begin
        state_d = SEND_SIZE; bcnt_d = '0;
      end
      SEND_SIZE: if (tx_ready) begin
        tx_load = 1'b1;
        tx_byte = size_q[{bcnt_q, 3'b000} +: 8];
        bcnt_d = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) begin
          if (size_q == '0) state_d = WAIT_RDY;
          else begin state_d = SEND_PROG; addr_d = '0; fetch_d = 2'd2; end
        end
      end
      SEND_PROG: begin
        // fetch_q: 2 = address just changed, 1 = prog_data valid to capture, 0 = word ready.
        if (fetch_q == 2'd2) fetch_d = 2'd1;
        else if (fetch_q == 2'd1) begin word_d = prog_data; fetch_d = 2'd0; end
        else if (tx_ready) begin
          tx_load = 1'b1;
          tx_byte = word_q[{bcnt_q, 3'b000} +: 8];
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            addr_d = addr_q + 30'd1;
            fetch_d = 2'd2;
            if (addr_q == size_q[31:2] - 30'd1) state_d = WAIT_RDY;
          end
        end
      end
      WAIT_RDY: if (rx_done && rx_sh_q == 8'haa) state_d = STREAM;
      STREAM: begin
        in_ready = tx_ready;
        if (in_valid && tx_ready) begin tx_load = 1'b1; tx_byte = in_data; end
        if (rx_done) begin out_valid_d = 1'b1; out_data_d = rx_sh_q; end
      end
      default: state_d = IDLE;
    endcase

    if (tx_load) begin
      tx_busy_d = 1'b1; tx_tmr_d = BIT_M1; tx_bit_d = '0; tx_dat_d = tx_byte; txd_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;    rx_st_q <= RX_IDLE;
      rx_s1_q <= 1'b1;    rx_s2_q <= 1'b1;     rx_prev_q <= 1'b1;
      rx_tmr_q <= '0;     rx_bit_q <= '0;      rx_sh_q <= '0;
      tx_tmr_q <= '0;     tx_bit_q <= '0;      tx_busy_q <= 1'b0;
      tx_dat_q <= '0;     txd_q <= 1'b1;       size_q <= '0;
      word_q <= '0;       addr_q <= '0;        bcnt_q <= '0;
      fetch_q <= '0;      size_err_q <= 1'b0;  frame_err_q <= 1'b0;
      out_data_q <= '0;   out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d; rx_st_q <= rx_st_d;
      rx_s1_q <= rxd;     rx_s2_q <= rx_s1_q;  rx_prev_q <= rx_s2_q;
      rx_tmr_q <= rx_tmr_d; rx_bit_q <= rx_bit_d; rx_sh_q <= rx_sh_d;
      tx_tmr_q <= tx_tmr_d; tx_bit_q <= tx_bit_d; tx_busy_q <= tx_busy_d;
      tx_dat_q <= tx_dat_d; txd_q <= txd_d;       size_q <= size_d;
      word_q <= word_d;     addr_q <= addr_d;     bcnt_q <= bcnt_d;
      fetch_q <= fetch_d;   size_err_q <= size_err_d; frame_err_q <= frame_err_d;
      out_data_q <= out_data_d; out_valid_q <= out_valid_d;
    end
  end

  assign txd       = txd_q;
  assign prog_addr = addr_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign state     = state_q;
  assign size_err  = size_err_q;
  assign frame_err = frame_err_q;
endmodule

// File: tb/tb_uart_host_loader.sv
// Bench for uart_host_loader: plays the core end of the link and checks against a byte-level model.
module tb_uart_host_loader;
  localparam int H = 4;
  localparam int B = 2 * H;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, rxd = 1'b1, txd;
  logic [31:0] prog_size = '0, prog_data = '0;
  logic [29:0] prog_addr;
  logic [7:0]  in_data = '0, out_data;
  logic        in_valid = 1'b0, in_ready, out_valid, size_err, frame_err;
  logic [2:0]  state;

  logic [31:0] mem [16];
  int cyc = 0, n_cmp = 0, n_err = 0;
  logic [7:0] exp_tx[$], got_log[$], exp_out[$];
  int tx_start[$], exp_out_t[$];
  bit mon_busy = 1'b0, mon_ignore = 1'b0;
  logic mon_prev = 1'b1;
  logic [7:0] last_out = '0;
  logic [7:0] lit_a [12] = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
                             8'hDD, 8'hCC, 8'hBB, 8'hAA};
  logic [7:0] lit_c [4] = '{8'h04, 8'h00, 8'h00, 8'h00};

  uart_host_loader #(.CLK_PER_HALF_BIT(H), .GAP_BITS(2)) dut (
    .clk(clk), .rst(rst), .start(start), .rxd(rxd), .txd(txd),
    .prog_size(prog_size), .prog_addr(prog_addr), .prog_data(prog_data),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .state(state),
    .size_err(size_err), .frame_err(frame_err));

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) prog_data <= mem[prog_addr[3:0]];

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int v, input int lo, input int hi);
    n_cmp++;
    if (v < lo || v > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d..%0d", name, v, lo, hi);
    end
  endtask

  // Serial monitor on txd: decodes 8N1 frames and compares against the expected byte stream.
  initial begin
    logic [7:0] b;
    logic sb;
    int t0;
    forever begin
      @(negedge clk);
      if (mon_prev && !txd && !rst) begin
        mon_busy = 1'b1;
        t0 = cyc;
        repeat (B / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (B) @(negedge clk);
          b[i] = txd;
        end
        repeat (B) @(negedge clk);
        sb = txd;
        if (mon_ignore) mon_ignore = 1'b0;
        else begin
          got_log.push_back(b);
          tx_start.push_back(t0);
          if (exp_tx.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL tx_byte: got %h, required no byte", b);
          end else chk("tx_byte", {24'd0, b}, {24'd0, exp_tx.pop_front()});
          chk("tx_stop", {31'd0, sb}, 32'd1);
        end
        mon_busy = 1'b0;
      end
      mon_prev = txd;
    end
  end

  // Per-cycle check of captured bytes against the queue of bytes the core has sent in STREAM.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (exp_out.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL out_valid: unexpected pulse with data %h, required none", out_data);
        end else begin
          chk("out_data", {24'd0, out_data}, {24'd0, exp_out.pop_front()});
          chk_rng("out_latency", cyc - exp_out_t.pop_front(), 9 * B + H, 10 * B + 2);
          last_out = out_data;
        end
      end else if (exp_out.size() != 0 && cyc - exp_out_t[0] > 10 * B + 10) begin
        n_cmp++; n_err++;
        $display("FAIL out_missing: byte %h not captured, required out_valid", exp_out[0]);
        void'(exp_out.pop_front());
        void'(exp_out_t.pop_front());
      end
    end
  end

  task automatic send_rx(input logic [7:0] b, input logic stop_bit, input bit expect_out);
    @(negedge clk);
    if (expect_out) begin exp_out.push_back(b); exp_out_t.push_back(cyc); end
    rxd = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin rxd = b[i]; repeat (B) @(negedge clk); end
    rxd = stop_bit;
    repeat (B) @(negedge clk);
    rxd = 1'b1;
    repeat (B) @(negedge clk);
  endtask

  task automatic send_in(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    in_data = b; in_valid = 1'b1;
    exp_tx.push_back(b);
    while (!in_ready && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) begin
      n_cmp++; n_err++;
      $display("FAIL in_ready_timeout: in_ready=0, required 1");
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("in_ready_drop", {31'd0, in_ready}, 32'd0);
  endtask

  // Model of the load session: latched size LSB first, then each program word LSB first.
  task automatic do_start(input logic [31:0] sz);
    logic [31:0] s4;
    @(negedge clk);
    prog_size = sz; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s4 = sz & 32'hFFFF_FFFC;
    for (int i = 0; i < 4; i++) exp_tx.push_back(8'((s4 >> (8 * i)) & 32'hFF));
    for (int w = 0; w < int'(s4 / 4); w++)
      for (int i = 0; i < 4; i++) exp_tx.push_back(8'((mem[w] >> (8 * i)) & 32'hFF));
  endtask

  task automatic do_reset();
    @(negedge clk);
    mon_ignore = mon_busy;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; rxd = 1'b1;
    exp_tx.delete(); exp_out.delete(); exp_out_t.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    got_log.delete(); tx_start.delete();
    @(negedge clk);
  endtask

  task automatic wait_tx(input int limit);
    int n = 0;
    while ((exp_tx.size() != 0 || mon_busy) && n < limit) begin @(negedge clk); n++; end
    n_cmp++;
    if (n >= limit) begin
      n_err++;
      $display("FAIL tx_drain: %0d bytes pending, required 0", exp_tx.size());
    end
  endtask

  task automatic wait_out(input int limit);
    int n = 0;
    while (exp_out.size() != 0 && n < limit) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int t_req, sz, n;
    logic [7:0] r;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;

    repeat (3) @(negedge clk);
    chk("rst_txd", {31'd0, txd}, 32'd1);
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_prog_addr", {2'd0, prog_addr}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_size_err", {31'd0, size_err}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic two-word load with junk before the request and repeated requests during transfer.
    mem[0] = 32'h1122_3344; mem[1] = 32'hAABB_CCDD;
    do_start(32'd8);
    chk("a_wait_req", {29'd0, state}, 32'd1);
    @(negedge clk); prog_size = 32'h40; start = 1'b1; @(negedge clk); start = 1'b0;
    send_rx(8'h5C, 1'b1, 1'b0);
    chk("a_junk_ignored", {29'd0, state}, 32'd1);
    t_req = cyc + 1;
    send_rx(8'h99, 1'b1, 1'b0);
    repeat (250) @(negedge clk);
    repeat (5) send_rx(8'h99, 1'b1, 1'b0);
    wait_tx(3000);
    chk("a_state", {29'd0, state}, 32'd4);
    chk("a_count", got_log.size(), 32'd12);
    for (int i = 0; i < 12; i++)
      if (i < got_log.size()) chk("a_literal", {24'd0, got_log[i]}, {24'd0, lit_a[i]});
    for (int i = 1; i < tx_start.size(); i++)
      chk("a_period", tx_start[i] - tx_start[i-1], 32'd80);
    if (tx_start.size() > 0) chk_rng("a_req_latency", tx_start[0] - t_req, 9 * B + H, 10 * B + 4);

    // Zero-size program.
    do_reset();
    do_start(32'd0);
    send_rx(8'h99, 1'b1, 1'b0);
    wait_tx(2000);
    chk("b_state", {29'd0, state}, 32'd4);
    chk("b_size_err", {31'd0, size_err}, 32'd0);
    chk("b_count", got_log.size(), 32'd4);

    // Unaligned size: rounded down, size_err set, single word.
    do_reset();
    do_start(32'd6);
    chk("c_size_err", {31'd0, size_err}, 32'd1);
    send_rx(8'h99, 1'b1, 1'b0);
    wait_tx(2000);
    chk("c_state", {29'd0, state}, 32'd4);
    chk("c_count", got_log.size(), 32'd8);
    for (int i = 0; i < 4; i++)
      if (i < got_log.size()) chk("c_literal", {24'd0, got_log[i]}, {24'd0, lit_c[i]});

    // Streaming phase.
    send_rx(8'h37, 1'b1, 1'b0);
    chk("d_wait_rdy", {29'd0, state}, 32'd4);
    send_rx(8'haa, 1'b1, 1'b0);
    chk("d_stream", {29'd0, state}, 32'd5);
    @(negedge clk); rxd = 1'b0; repeat (3) @(negedge clk); rxd = 1'b1;
    repeat (100) @(negedge clk);
    chk("d_glitch_no_err", {31'd0, frame_err}, 32'd0);
    send_in(8'h41);
    wait_tx(2000);
    send_rx(8'h5A, 1'b1, 1'b1);
    wait_out(200);
    chk("d_last_out", {24'd0, last_out}, 32'h5A);
    for (int k = 0; k < 4; k++) begin
      r = 8'($urandom);
      fork
        send_in(8'($urandom));
        send_rx(r, 1'b1, 1'b1);
      join
      wait_tx(2000);
      wait_out(200);
    end
    send_rx(8'h3C, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    chk("d_frame_err", {31'd0, frame_err}, 32'd1);

    // Randomized load sessions against the model.
    for (int k = 0; k < 3; k++) begin
      do_reset();
      for (int i = 0; i < 16; i++) mem[i] = $urandom;
      sz = int'($urandom_range(0, 18));
      do_start(sz);
      chk("r_size_err", {31'd0, size_err}, {31'd0, (sz % 4) != 0});
      send_rx(8'h99, 1'b1, 1'b0);
      wait_tx(4000);
      chk("r_state", {29'd0, state}, 32'd4);
    end

    // Asynchronous reset in the middle of a size byte, then a fresh session.
    do_reset();
    mem[0] = 32'h1122_3344; mem[1] = 32'hAABB_CCDD;
    do_start(32'd8);
    send_rx(8'h99, 1'b1, 1'b0);
    n = 0;
    while (tx_start.size() == 0 && !mon_busy && n < 500) begin @(negedge clk); n++; end
    repeat (20) @(negedge clk);
    #2;
    rst = 1'b1;
    mon_ignore = mon_busy;
    exp_tx.delete();
    #1;
    chk("e_txd", {31'd0, txd}, 32'd1);
    chk("e_state", {29'd0, state}, 32'd0);
    chk("e_prog_addr", {2'd0, prog_addr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    got_log.delete(); tx_start.delete();
    do_start(32'd8);
    chk("e_wait_req", {29'd0, state}, 32'd1);
    send_rx(8'h99, 1'b1, 1'b0);
    wait_tx(3000);
    chk("e_state_end", {29'd0, state}, 32'd4);
    chk("e_count", got_log.size(), 32'd12);

    repeat (20) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
